// File: rtl/signal_lights_pkg.sv
// Shared phase codes, fault codes and per-light lamp encodings for the
// intersection signal lights (command path, monitor and bench).
package signal_lights_pkg;

    typedef enum logic [2:0] {
        PH_ALL_RED = 3'd0,
        PH_L3_GO   = 3'd1,
        PH_L3_YEL  = 3'd2,
        PH_L1_LEFT = 3'd3,
        PH_L1_YEL  = 3'd4,
        PH_L2_GO   = 3'd5,
        PH_L2_YEL  = 3'd6
    } phase_e;

    typedef enum logic [2:0] {
        FLT_NONE         = 3'd0,
        FLT_LAMP         = 3'd1,
        FLT_CONFLICT     = 3'd2,
        FLT_SEQUENCE     = 3'd3,
        FLT_SHORT_YELLOW = 3'd4,
        FLT_STUCK        = 3'd5
    } fault_e;

    // Light 1 lamps ordered {red, yellow, left}
    localparam logic [2:0] L1_LAMP_RED    = 3'b100;
    localparam logic [2:0] L1_LAMP_YELLOW = 3'b010;
    localparam logic [2:0] L1_LAMP_LEFT   = 3'b001;
    // Light 2 lamps ordered {red, yellow, green}
    localparam logic [2:0] L2_LAMP_RED    = 3'b100;
    localparam logic [2:0] L2_LAMP_YELLOW = 3'b010;
    localparam logic [2:0] L2_LAMP_GREEN  = 3'b001;
    // Light 3 lamps ordered {red, yellow, green, left}
    localparam logic [3:0] L3_LAMP_RED        = 4'b1000;
    localparam logic [3:0] L3_LAMP_YELLOW     = 4'b0100;
    localparam logic [3:0] L3_LAMP_GREEN      = 4'b0010;
    localparam logic [3:0] L3_LAMP_GREEN_LEFT = 4'b0011;

    // Successor of a phase in the legal rotation; ALL_RED only ever leads to L3_GO.
    function automatic phase_e next_phase(input phase_e cur);
        case (cur)
            PH_ALL_RED: next_phase = PH_L3_GO;
            PH_L3_GO:   next_phase = PH_L3_YEL;
            PH_L3_YEL:  next_phase = PH_L1_LEFT;
            PH_L1_LEFT: next_phase = PH_L1_YEL;
            PH_L1_YEL:  next_phase = PH_L2_GO;
            PH_L2_GO:   next_phase = PH_L2_YEL;
            PH_L2_YEL:  next_phase = PH_L3_GO;
            default:    next_phase = PH_L3_GO;
        endcase
    endfunction

    function automatic logic is_yellow(input phase_e p);
        is_yellow = (p == PH_L3_YEL) || (p == PH_L1_YEL) || (p == PH_L2_YEL);
    endfunction

endpackage

// File: rtl/signal_status_monitor_lamp_pattern_decode.sv
// Combinational decode of the ten lamp outputs into per-light validity,
// phase legality and the matching phase code.
module lamp_pattern_decode
    import signal_lights_pkg::*;
(
    input  logic [9:0] lamps,
    output logic       lamp_ok,
    output logic       legal,
    output phase_e     phase_code
);

    logic [2:0] l1_s;
    logic [2:0] l2_s;
    logic [3:0] l3_s;
    logic       l1_ok_s;
    logic       l2_ok_s;
    logic       l3_ok_s;

    assign l1_s    = lamps[9:7];
    assign l2_s    = lamps[6:4];
    assign l3_s    = lamps[3:0];
    assign l1_ok_s = $onehot(l1_s);
    assign l2_ok_s = $onehot(l2_s);
    assign l3_ok_s = $onehot(l3_s) || (l3_s == L3_LAMP_GREEN_LEFT);

    // Match the lamp-valid pattern against the seven phase templates.
    always_comb begin
        lamp_ok    = l1_ok_s && l2_ok_s && l3_ok_s;
        legal      = 1'b0;
        phase_code = PH_ALL_RED;
        if (!lamp_ok) begin
            legal = 1'b0;
        end else if (l1_s == L1_LAMP_RED && l2_s == L2_LAMP_RED && l3_s == L3_LAMP_RED) begin
            legal      = 1'b1;
            phase_code = PH_ALL_RED;
        end else if (l1_s == L1_LAMP_RED && l2_s == L2_LAMP_RED &&
                     (l3_s == L3_LAMP_GREEN || l3_s == L3_LAMP_GREEN_LEFT)) begin
            legal      = 1'b1;
            phase_code = PH_L3_GO;
        end else if (l1_s == L1_LAMP_RED && l2_s == L2_LAMP_RED && l3_s == L3_LAMP_YELLOW) begin
            legal      = 1'b1;
            phase_code = PH_L3_YEL;
        end else if (l1_s == L1_LAMP_LEFT && l2_s == L2_LAMP_RED && l3_s == L3_LAMP_RED) begin
            legal      = 1'b1;
            phase_code = PH_L1_LEFT;
        end else if (l1_s == L1_LAMP_YELLOW && l2_s == L2_LAMP_RED && l3_s == L3_LAMP_RED) begin
            legal      = 1'b1;
            phase_code = PH_L1_YEL;
        end else if (l1_s == L1_LAMP_RED && l2_s == L2_LAMP_GREEN && l3_s == L3_LAMP_RED) begin
            legal      = 1'b1;
            phase_code = PH_L2_GO;
        end else if (l1_s == L1_LAMP_RED && l2_s == L2_LAMP_YELLOW && l3_s == L3_LAMP_RED) begin
            legal      = 1'b1;
            phase_code = PH_L2_YEL;
        end else begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/signal_status_monitor.sv
// Read-back monitor for the intersection lamps: settle filter, phase
// sequencer, dwell timer and first-fault latch.
module signal_status_monitor
    import signal_lights_pkg::*;
#(
    parameter int unsigned SETTLE     = 1,
    parameter int unsigned YELLOW_MIN = 3,
    parameter int unsigned MAX_DWELL  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L1_red,
    input  logic       L1_yellow,
    input  logic       L1_left,
    input  logic       L2_red,
    input  logic       L2_yellow,
    input  logic       L2_green,
    input  logic       L3_red,
    input  logic       L3_yellow,
    input  logic       L3_green,
    input  logic       L3_left,
    output logic [2:0] phase,
    output logic       phase_valid,
    output logic       phase_change,
    output logic [7:0] dwell,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [2:0] SETTLE_C     = 3'(SETTLE);
    localparam logic [7:0] YELLOW_MIN_C = 8'(YELLOW_MIN);
    localparam logic [7:0] MAX_DWELL_C  = 8'(MAX_DWELL);

    logic [9:0] lamps_s;
    logic [9:0] pat_q_r;
    logic [9:0] prev_pat_r;
    logic [9:0] acc_pat_r;
    logic [2:0] stab_cnt_r;
    logic [2:0] stab_cnt_s;
    logic       accept_s;
    logic       lamp_ok_s;
    logic       legal_s;
    phase_e     dec_phase_s;
    phase_e     phase_r;
    logic       phase_valid_r;
    logic       phase_change_r;
    logic [7:0] dwell_r;
    logic [7:0] dwell_s;
    logic       fault_r;
    fault_e     fault_code_r;
    logic       upd_s;
    logic       f_lamp_s;
    logic       f_conf_s;
    logic       f_seq_s;
    logic       f_short_s;
    logic       f_stuck_s;
    fault_e     new_fault_s;

    assign lamps_s = {L1_red, L1_yellow, L1_left, L2_red, L2_yellow, L2_green,
                      L3_red, L3_yellow, L3_green, L3_left};

    assign phase        = phase_r;
    assign phase_valid  = phase_valid_r;
    assign phase_change = phase_change_r;
    assign dwell        = dwell_r;
    assign fault        = fault_r;
    assign fault_code   = fault_code_r;

    lamp_pattern_decode u_decode (
        .lamps      (pat_q_r),
        .lamp_ok    (lamp_ok_s),
        .legal      (legal_s),
        .phase_code (dec_phase_s)
    );

    // Sample the lamps and track how long the sampled pattern has been stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q_r    <= 10'd0;
            prev_pat_r <= 10'd0;
            stab_cnt_r <= 3'd0;
        end else begin
            pat_q_r    <= lamps_s;
            prev_pat_r <= pat_q_r;
            stab_cnt_r <= stab_cnt_s;
        end
    end

    // Stability count for the current sample and the acceptance decision.
    always_comb begin
        stab_cnt_s = stab_cnt_r;
        if (pat_q_r != prev_pat_r) begin
            stab_cnt_s = 3'd1;
        end else if (stab_cnt_r != 3'd7) begin
            stab_cnt_s = stab_cnt_r + 3'd1;
        end else begin
            stab_cnt_s = stab_cnt_r;
        end
        accept_s = (stab_cnt_s == SETTLE_C) && (pat_q_r != acc_pat_r);
    end

    // Classify an accepted pattern: lamp/conflict faults hold the phase, legal
    // patterns advance it and are checked against the rotation and yellow minimum.
    always_comb begin
        upd_s     = 1'b0;
        f_lamp_s  = 1'b0;
        f_conf_s  = 1'b0;
        f_seq_s   = 1'b0;
        f_short_s = 1'b0;
        if (accept_s) begin
            if (!lamp_ok_s) begin
                f_lamp_s = 1'b1;
            end else if (!legal_s) begin
                f_conf_s = 1'b1;
            end else if (!phase_valid_r) begin
                upd_s   = 1'b1;
                f_seq_s = (dec_phase_s != PH_ALL_RED) && (dec_phase_s != PH_L3_GO);
            end else if (dec_phase_s != phase_r) begin
                upd_s     = 1'b1;
                f_seq_s   = (dec_phase_s != next_phase(phase_r));
                f_short_s = is_yellow(phase_r) && (dwell_r < YELLOW_MIN_C);
            end else begin
                upd_s = 1'b0;
            end
        end else begin
            upd_s = 1'b0;
        end
    end

    // Dwell timer, stuck detection and fault priority selection.
    always_comb begin
        if (upd_s) begin
            dwell_s = 8'd1;
        end else if (phase_valid_r && (dwell_r != 8'hFF)) begin
            dwell_s = dwell_r + 8'd1;
        end else begin
            dwell_s = dwell_r;
        end
        f_stuck_s = phase_valid_r && !upd_s && (dwell_s == MAX_DWELL_C);
        if (f_lamp_s) begin
            new_fault_s = FLT_LAMP;
        end else if (f_conf_s) begin
            new_fault_s = FLT_CONFLICT;
        end else if (f_seq_s) begin
            new_fault_s = FLT_SEQUENCE;
        end else if (f_short_s) begin
            new_fault_s = FLT_SHORT_YELLOW;
        end else if (f_stuck_s) begin
            new_fault_s = FLT_STUCK;
        end else begin
            new_fault_s = FLT_NONE;
        end
    end

    // Accepted-pattern, phase, dwell and sticky first-fault registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_pat_r      <= 10'd0;
            phase_r        <= PH_ALL_RED;
            phase_valid_r  <= 1'b0;
            phase_change_r <= 1'b0;
            dwell_r        <= 8'd0;
            fault_r        <= 1'b0;
            fault_code_r   <= FLT_NONE;
        end else begin
            if (accept_s) begin
                acc_pat_r <= pat_q_r;
            end
            if (upd_s) begin
                phase_r       <= dec_phase_s;
                phase_valid_r <= 1'b1;
            end
            phase_change_r <= upd_s;
            dwell_r        <= dwell_s;
            if (!fault_r && (new_fault_s != FLT_NONE)) begin
                fault_r      <= 1'b1;
                fault_code_r <= new_fault_s;
            end
        end
    end

endmodule

// File: tb/tb_signal_status_monitor.sv
// Bench for signal_status_monitor: two instances (SETTLE=1 and SETTLE=2) share
// the lamp stimulus and are compared every cycle against a behavioural model.
module tb_signal_status_monitor;

    localparam int YMIN = 3;
    localparam int MAXD = 120;

    // Lamp vector order {L1 r,y,left, L2 r,y,g, L3 r,y,g,left}
    localparam logic [9:0] P_ALLRED = 10'b100_100_1000;
    localparam logic [9:0] P_L3GO   = 10'b100_100_0010;
    localparam logic [9:0] P_L3GOL  = 10'b100_100_0011;
    localparam logic [9:0] P_L3Y    = 10'b100_100_0100;
    localparam logic [9:0] P_L1L    = 10'b001_100_1000;
    localparam logic [9:0] P_L1Y    = 10'b010_100_1000;
    localparam logic [9:0] P_L2G    = 10'b100_001_1000;
    localparam logic [9:0] P_L2Y    = 10'b100_010_1000;
    localparam logic [9:0] P_CONF   = 10'b100_001_0010;
    localparam logic [9:0] P_LAMP   = 10'b110_100_0010;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] lamps;
    logic [2:0] phase_o [2];
    logic       valid_o [2];
    logic       chg_o   [2];
    logic [7:0] dwell_o [2];
    logic       fault_o [2];
    logic [2:0] code_o  [2];

    int n_checks = 0;
    int n_errors = 0;

    // model state per instance
    int         m_settle [2];
    logic [9:0] m_last   [2];
    int         m_run    [2];
    logic [9:0] m_acc    [2];
    int         m_phase  [2];
    bit         m_valid  [2];
    bit         m_chg    [2];
    int         m_dwell  [2];
    int         m_code   [2];

    always #5 clk = ~clk;

    signal_status_monitor #(.SETTLE(1), .YELLOW_MIN(YMIN), .MAX_DWELL(MAXD)) dut_s1 (
        .clk(clk), .reset(reset),
        .L1_red(lamps[9]), .L1_yellow(lamps[8]), .L1_left(lamps[7]),
        .L2_red(lamps[6]), .L2_yellow(lamps[5]), .L2_green(lamps[4]),
        .L3_red(lamps[3]), .L3_yellow(lamps[2]), .L3_green(lamps[1]), .L3_left(lamps[0]),
        .phase(phase_o[0]), .phase_valid(valid_o[0]), .phase_change(chg_o[0]),
        .dwell(dwell_o[0]), .fault(fault_o[0]), .fault_code(code_o[0])
    );

    signal_status_monitor #(.SETTLE(2), .YELLOW_MIN(YMIN), .MAX_DWELL(MAXD)) dut_s2 (
        .clk(clk), .reset(reset),
        .L1_red(lamps[9]), .L1_yellow(lamps[8]), .L1_left(lamps[7]),
        .L2_red(lamps[6]), .L2_yellow(lamps[5]), .L2_green(lamps[4]),
        .L3_red(lamps[3]), .L3_yellow(lamps[2]), .L3_green(lamps[1]), .L3_left(lamps[0]),
        .phase(phase_o[1]), .phase_valid(valid_o[1]), .phase_change(chg_o[1]),
        .dwell(dwell_o[1]), .fault(fault_o[1]), .fault_code(code_o[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Phase of a pattern from which lights are non-red; ok/legal as flags.
    function automatic void decode(input logic [9:0] p, output bit ok, output bit lg, output int ph);
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] c;
        int nonred;
        a = p[9:7]; b = p[6:4]; c = p[3:0];
        ok = ($countones(a) == 1) && ($countones(b) == 1) &&
             (($countones(c) == 1) || (c == 4'b0011));
        lg = 1'b0; ph = 0; nonred = 0;
        if (!a[2]) nonred++;
        if (!b[2]) nonred++;
        if (!c[3]) nonred++;
        if (ok && nonred == 0) begin
            lg = 1'b1; ph = 0;
        end else if (ok && nonred == 1) begin
            if (!c[3]) begin
                if (c[1]) begin lg = 1'b1; ph = 1; end
                else if (c[2]) begin lg = 1'b1; ph = 2; end
            end else if (!a[2]) begin
                lg = 1'b1; ph = a[0] ? 3 : 4;
            end else begin
                lg = 1'b1; ph = b[0] ? 5 : 6;
            end
        end
    endfunction

    // Advance the model by one clock edge with lamps l and reset r.
    task automatic model_edge(input int i, input logic [9:0] l, input bit r);
        bit ok, lg, upd;
        int ph, cand, runc, expn;
        if (r) begin
            m_last[i] = 10'd0; m_run[i] = 1; m_acc[i] = 10'd0;
            m_phase[i] = 0; m_valid[i] = 1'b0; m_chg[i] = 1'b0;
            m_dwell[i] = 0; m_code[i] = 0;
            return;
        end
        cand = 0; upd = 1'b0;
        runc = (m_run[i] > 7) ? 7 : m_run[i];
        if (runc == m_settle[i] && m_last[i] != m_acc[i]) begin
            m_acc[i] = m_last[i];
            decode(m_last[i], ok, lg, ph);
            if (!ok) cand = 1;
            else if (!lg) cand = 2;
            else if (!m_valid[i]) begin
                if (ph > 1) cand = 3;
                upd = 1'b1;
            end else if (ph != m_phase[i]) begin
                expn = (m_phase[i] == 0) ? 1 : (m_phase[i] % 6) + 1;
                if (ph != expn) cand = 3;
                else if ((m_phase[i] % 2 == 0) && m_phase[i] != 0 && m_dwell[i] < YMIN) cand = 4;
                upd = 1'b1;
            end
        end
        m_chg[i] = upd;
        if (upd) begin
            m_phase[i] = ph; m_valid[i] = 1'b1; m_dwell[i] = 1;
        end else if (m_valid[i]) begin
            if (m_dwell[i] < 255) m_dwell[i]++;
            if (m_dwell[i] == MAXD && cand == 0) cand = 5;
        end
        if (m_code[i] == 0 && cand != 0) m_code[i] = cand;
        if (l == m_last[i]) begin
            if (m_run[i] < 1000) m_run[i]++;
        end else begin
            m_run[i] = 1; m_last[i] = l;
        end
    endtask

    task automatic tick(input logic [9:0] l, input bit r);
        lamps = l; reset = r;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, l, r);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("phase%0d", i), 32'(phase_o[i]), 32'(m_phase[i]));
            check_eq($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(m_valid[i]));
            check_eq($sformatf("change%0d", i), 32'(chg_o[i]), 32'(m_chg[i]));
            check_eq($sformatf("dwell%0d", i), 32'(dwell_o[i]), 32'(m_dwell[i]));
            check_eq($sformatf("fault%0d", i), 32'(fault_o[i]), 32'(m_code[i] != 0));
            check_eq($sformatf("code%0d", i), 32'(code_o[i]), 32'(m_code[i]));
        end
    endtask

    task automatic hold(input logic [9:0] l, input int n);
        for (int k = 0; k < n; k++) tick(l, 1'b0);
    endtask

    task automatic start_l3go();
        tick(P_ALLRED, 1'b1);
        tick(P_ALLRED, 1'b1);
        hold(P_ALLRED, 2);
        hold(P_L3GO, 3);
    endtask

    function automatic logic [9:0] pat_of(input int ph, input bit left);
        case (ph)
            0: pat_of = P_ALLRED;
            1: pat_of = left ? P_L3GOL : P_L3GO;
            2: pat_of = P_L3Y;
            3: pat_of = P_L1L;
            4: pat_of = P_L1Y;
            5: pat_of = P_L2G;
            6: pat_of = P_L2Y;
            default: pat_of = P_ALLRED;
        endcase
    endfunction

    initial begin
        int rphase, act, n, prev;
        logic [9:0] rp;
        m_settle[0] = 1; m_settle[1] = 2;
        lamps = P_ALLRED; reset = 1'b1;
        @(negedge clk);

        // reset, all-red 3 cycles, then L3 green
        tick(P_ALLRED, 1'b1);
        tick(P_ALLRED, 1'b1);
        check_eq("rst_phase", 32'(phase_o[0]), 32'd0);
        check_eq("rst_valid", 32'(valid_o[0]), 32'd0);
        check_eq("rst_dwell", 32'(dwell_o[0]), 32'd0);
        hold(P_ALLRED, 3);
        check_eq("allred_valid", 32'(valid_o[0]), 32'd1);
        tick(P_L3GO, 1'b0);
        check_eq("l3go_nochg_yet", 32'(chg_o[0]), 32'd0);
        tick(P_L3GO, 1'b0);
        check_eq("l3go_chg", 32'(chg_o[0]), 32'd1);
        check_eq("l3go_phase", 32'(phase_o[0]), 32'd1);
        hold(P_L3GO, 2);

        // full legal cycle, yellows held 3 cycles
        prev = 1;
        for (int ph = 2; ph <= 7; ph++) begin
            n = (ph == 7) ? 1 : ph;
            tick(pat_of(n, 1'b0), 1'b0);
            if (prev % 2 == 0) begin
                check_eq("yel_last_dwell", 32'(dwell_o[0]), 32'd3);
                check_eq("yel_last_phase", 32'(phase_o[0]), 32'(prev));
            end
            hold(pat_of(n, 1'b0), (n % 2 == 0) ? 2 : 3);
            prev = n;
        end
        check_eq("cycle_fault_s1", 32'(fault_o[0]), 32'd0);
        check_eq("cycle_fault_s2", 32'(fault_o[1]), 32'd0);

        // conflict, then a later lamp fault keeps the first code
        start_l3go();
        hold(P_CONF, 3);
        check_eq("conf_code_s1", 32'(code_o[0]), 32'd2);
        check_eq("conf_code_s2", 32'(code_o[1]), 32'd2);
        check_eq("conf_phase", 32'(phase_o[0]), 32'd1);
        hold(P_LAMP, 3);
        check_eq("conf_sticky", 32'(code_o[0]), 32'd2);

        // one-cycle glitch filtered by SETTLE=2, two-cycle hold is a lamp fault
        start_l3go();
        tick(P_LAMP, 1'b0);
        hold(P_L3GO, 3);
        check_eq("glitch_s2", 32'(fault_o[1]), 32'd0);
        hold(P_LAMP, 2);
        tick(P_L3GO, 1'b0);
        check_eq("lamp_s2", 32'(code_o[1]), 32'd1);

        // short yellow, then sequence skip
        start_l3go();
        hold(P_L3Y, 2);
        hold(P_L1L, 3);
        check_eq("short_yel", 32'(code_o[0]), 32'd4);
        start_l3go();
        hold(P_L1L, 3);
        check_eq("seq_skip", 32'(code_o[0]), 32'd3);

        // stuck phase, then reset mid-phase
        start_l3go();
        hold(P_L3GO, 127);
        check_eq("stuck_code", 32'(code_o[0]), 32'd5);
        tick(P_L3GO, 1'b1);
        check_eq("midrst_code", 32'(code_o[0]), 32'd0);
        check_eq("midrst_dwell", 32'(dwell_o[0]), 32'd0);
        check_eq("midrst_phase", 32'(phase_o[0]), 32'd0);

        // randomized traffic with glitches, skips, long holds and resets
        rphase = 0;
        hold(P_ALLRED, 3);
        for (int it = 0; it < 300; it++) begin
            act = $urandom_range(0, 99);
            if (act < 70) begin
                rphase = (rphase == 0) ? 1 : (rphase % 6) + 1;
                hold(pat_of(rphase, 1'($urandom_range(0, 1))), $urandom_range(1, 6));
            end else if (act < 80) begin
                rp = 10'($urandom);
                hold(rp, $urandom_range(1, 3));
            end else if (act < 86) begin
                for (int k = 0; k < $urandom_range(1, 2); k++) tick(P_ALLRED, 1'b1);
                rphase = 0;
                hold(P_ALLRED, $urandom_range(1, 3));
            end else if (act < 92) begin
                rphase = (rphase % 6) + 2;
                if (rphase > 6) rphase = rphase - 6;
                hold(pat_of(rphase, 1'b0), $urandom_range(1, 5));
            end else begin
                hold(pat_of(rphase, 1'b0), $urandom_range(115, 125));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/signal_status_monitor.md
# signal_status_monitor

Observation-side counterpart of the `control` command path: `control` drives the `L1_cmd`/`L2_cmd`/`L3_cmd` codes into the lamp drivers, and this block reads the ten lamp outputs back. It decodes them into an intersection phase, times how long each phase is held and checks the phase order. It latches the first lamp, conflict, sequence or timing violation as a sticky fault. It sits beside `light1_2`/`light3` in the intersection top level and in `signal_lights_tb`, with no feedback into `control`.

## Interface
- `SETTLE`, 1, consecutive identical sampled patterns required before a pattern is accepted (1..7)
- `YELLOW_MIN`, 3, minimum cycles a yellow phase must be held
- `MAX_DWELL`, 120, maximum cycles any phase may be held (≤254)
- `clk` in 1 single clock (1 Hz in system)
- `reset` in 1 synchronous, active-high
- `L1_red`, `L1_yellow`, `L1_left` in 1 each, light 1 lamps
- `L2_red`, `L2_yellow`, `L2_green` in 1 each, light 2 lamps
- `L3_red`, `L3_yellow`, `L3_green`, `L3_left` in 1 each, light 3 lamps
- `phase` out 3 accepted phase code
- `phase_valid` out 1 high once the first legal phase is accepted
- `phase_change` out 1 one-cycle pulse when `phase` updates
- `dwell` out 8 cycles the current phase has been held, saturating at 255
- `fault` out 1 sticky, high once any fault is latched
- `fault_code` out 3 first fault: 0 none, 1 LAMP, 2 CONFLICT, 3 SEQUENCE, 4 SHORT_YELLOW, 5 STUCK

## Operation
- Phases:
  - 0 ALL_RED: all three lights red.
  - 1 L3_GO: L3 green, optionally with L3 left; L1 and L2 red.
  - 2 L3_YEL: L3 yellow; L1 and L2 red.
  - 3 L1_LEFT: L1 left; L2 and L3 red.
  - 4 L1_YEL: L1 yellow; L2 and L3 red.
  - 5 L2_GO: L2 green; L1 and L3 red.
  - 6 L2_YEL: L2 yellow; L1 and L3 red.
- Per-light lamp rule: exactly one lamp is lit. The only exception is L3 green+left together. Any violation is LAMP.
- A lamp-valid pattern that matches no phase is CONFLICT, for example two non-red lights.
- Legal order: 1→2→3→4→5→6→1. ALL_RED is legal only as the first accepted phase and must be followed by 1. The first accepted phase must be 0 or 1; otherwise SEQUENCE.
- Lamp, conflict and sequence checks run on accepted patterns only. Transients shorter than `SETTLE` never fault.
- Leaving phase 2, 4 or 6 with `dwell < YELLOW_MIN` raises SHORT_YELLOW.
- `dwell` reaching `MAX_DWELL` with no change accepted in that cycle raises STUCK.
- On a LAMP or CONFLICT pattern, `phase` holds its previous value and `phase_change` does not pulse.
- The fault latch captures only the first fault. If several faults occur in the same cycle, priority is LAMP > CONFLICT > SEQUENCE > SHORT_YELLOW > STUCK.
- After a fault, decoding, `phase` and `dwell` keep updating. `fault`/`fault_code` hold until `reset`.

## Timing
- Reset values: `phase`=0, `phase_valid`=0, `phase_change`=0, `dwell`=0, `fault`=0, `fault_code`=0; input sample register and stability counter are cleared.
- Stage 1: lamps are registered every edge into `pat_q`.
- Stage 2: the stability counter is set to 1 when `pat_q` differs from the previous `pat_q`, otherwise it increments, saturating at 7. A pattern is accepted when the count equals `SETTLE` and the pattern differs from the accepted pattern.
- Latency: a lamp change sampled at edge k updates `phase`, pulses `phase_change` and latches any fault at edge k+SETTLE.
- On acceptance, `dwell` loads 1. Otherwise it increments each cycle while `phase_valid`, saturating at 255.
- Reset asserted mid-phase clears everything at the next edge. The next accepted phase is treated as the first phase.

## Structure
- `signal_lights_pkg` holds the phase codes, fault codes and the per-light lamp-encoding constants, shared with `control` and the bench.
- Natural sub-module: `lamp_pattern_decode`, a combinational block from 10 lamps to {lamp_ok, legal, phase_code}. The settle filter, sequencer, dwell counter and fault latch live in the top.

## Test plan
- Reset, then all-red held for 3 cycles, then L3 green: `phase` goes 0→1, `phase_valid`=1, `phase_change` pulses once 2 edges after the L3 change, `fault`=0.
- Full legal cycle 1..6→1 with a 3-cycle yellow hold: no fault, and `dwell` reads 3 in the last cycle of each yellow phase.
- L2 green asserted while L3 green: `fault_code`=2 at SETTLE+1 edges and `phase` unchanged. A later LAMP fault leaves the code at 2.
- L1 red and yellow together for 1 cycle with `SETTLE`=2: no fault. The same pattern held for 2 cycles: `fault_code`=1.
- L3_YEL held 2 cycles then L1_LEFT: `fault_code`=4. Separately, phase 3 after 1: `fault_code`=3.
- L3_GO held 130 cycles: `fault_code`=5 when `dwell` reaches 120. Reset mid-phase: all outputs return to 0 next edge.
